// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Frame geometry and transmitter state encoding.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS      = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick.
// Lowest offset from ptr_i wins among asserted valids.
module uart_rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         valid_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  function automatic int wrap(input int p, input int k);
    int s;
    s = p + k;
    return (s >= N) ? s - N : s;
  endfunction

  // Scan farthest offset first so the nearest valid overwrites.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid_i[wrap(int'(ptr_i), k)]) begin
        gnt_o = '0;
        gnt_o[wrap(int'(ptr_i), k)] = 1'b1;
        idx_o = IW'(wrap(int'(ptr_i), k));
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shared UART transmitter with round-robin source selection.
// Outputs are registered from state, so tx trails the FSM by one clk.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx,
  output logic                       busy,
  output logic                       done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(OVERSAMPLE);

  tx_state_e              state_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [CW-1:0]          tick_cnt_q;
  logic [2:0]             bit_idx_q;
  logic [IW-1:0]          rr_ptr_q;
  logic [IW-1:0]          grant_id_q;
  logic [NUM_REQ-1:0]     ready_q;
  logic                   tx_q;
  logic                   busy_q;
  logic                   done_q;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IW-1:0]          arb_idx;
  logic                   arb_any;
  logic [IW-1:0]          rr_ptr_d;
  logic [CW-1:0]          tick_cnt_d;
  logic                   bit_end;

  uart_rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign bit_end    = tick && (tick_cnt_q == CW'(OVERSAMPLE - 1));
  assign tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
  assign rr_ptr_d   = (arb_idx == IW'(NUM_REQ - 1)) ? '0
                                                     : arb_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      ready_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ready_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= (state_q != IDLE);
      unique case (state_q)
        IDLE:  tx_q <= 1'b1;
        START: tx_q <= 1'b0;
        DATA:  tx_q <= shift_q[0];
        STOP:  tx_q <= 1'b1;
      endcase
      unique case (state_q)
        IDLE: begin
          if (arb_any) begin
            ready_q    <= arb_gnt;
            shift_q    <= req_data[8*arb_idx +: 8];
            grant_id_q <= arb_idx;
            rr_ptr_q   <= rr_ptr_d;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            state_q    <= START;
          end
        end
        START: begin
          if (tick) tick_cnt_q <= tick_cnt_d;
          if (bit_end) state_q <= DATA;
        end
        DATA: begin
          if (tick) tick_cnt_q <= tick_cnt_d;
          if (bit_end) begin
            shift_q   <= shift_q >> 1;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'(DATA_BITS - 1)) state_q <= STOP;
          end
        end
        STOP: begin
          if (tick) tick_cnt_q <= tick_cnt_d;
          if (bit_end) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign grant_id  = grant_id_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
